// File: rtl/instr_sequencer_pkg.sv
// Shared ISA definitions for the instruction sequencer: opcodes, flag bit positions, FSM states.
// SEQ_SINGLE_STEP_EN adds the STEP_WAIT state used by the single-step build.
package instr_sequencer_pkg;

  localparam int INSTR_W = 15;
  localparam int OPC_W   = 7;
  localparam int LIT_W   = 8;

  localparam logic [OPC_W-1:0] OP_ALU_LAST = 7'h24;
  localparam logic [OPC_W-1:0] OP_JMP      = 7'h40;
  localparam logic [OPC_W-1:0] OP_JEQ      = 7'h41;
  localparam logic [OPC_W-1:0] OP_JNE      = 7'h42;
  localparam logic [OPC_W-1:0] OP_JGT      = 7'h43;
  localparam logic [OPC_W-1:0] OP_JLT      = 7'h44;
  localparam logic [OPC_W-1:0] OP_HALT     = 7'h7F;

  // Bit positions inside the {Z,N,C,V} status vector.
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_EXEC      = 3'd2,
    ST_HALT      = 3'd3
`ifdef SEQ_SINGLE_STEP_EN
    , ST_STEP_WAIT = 3'd4
`endif
  } state_t;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [LIT_W-1:0] k8;
  } instr_t;

  // ALU/MOV/INC opcodes occupy the bottom of the opcode space.
  function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
    return op <= OP_ALU_LAST;
  endfunction

endpackage

// File: rtl/instr_sequencer_branch_eval.sv
// Combinational jump decoder: classifies the opcode as a jump and decides whether it is taken
// from the {Z,N,C,V} status flags.
module branch_eval
  import instr_sequencer_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  logic [3:0]       flags,
  output logic             is_jump,
  output logic             take
);

  logic flag_z;
  logic flag_n;
  logic unused_flags;

  assign flag_z       = flags[FLAG_Z];
  assign flag_n       = flags[FLAG_N];
  // C and V are not consulted by any current jump condition.
  assign unused_flags = flags[FLAG_C] ^ flags[FLAG_V];

  // NOTE: every output gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    is_jump = 1'b1;
    take    = 1'b0;
    case (opcode)
      OP_JMP:  take = 1'b1;
      OP_JEQ:  take = flag_z;
      OP_JNE:  take = !flag_z;
      OP_JGT:  take = !flag_n && !flag_z;
      OP_JLT:  take = flag_n;
      default: is_jump = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/issue FSM in front of control_unit: fetches {opcode,k8} over req/ack, issues ALU ops,
// resolves jumps and holds the PC. SEQ_SINGLE_STEP_EN adds a step input and STEP_WAIT state.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic               step,
`endif
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic [3:0]         flags_status,
  output logic [OPC_W-1:0]   opcode_o,
  output logic [LIT_W-1:0]   lit_o,
  output logic               issue,
  output logic [PC_W-1:0]    pc_o,
  output logic               busy,
  output logic               halted
);

  state_t          state;
  state_t          state_next;
  logic [PC_W-1:0] pc;
  instr_t          word;
  logic            is_jump;
  logic            take;

  assign word = instr_t'(imem_data);

  branch_eval u_branch_eval (
    .opcode  (opcode_o),
    .flags   (flags_status),
    .is_jump (is_jump),
    .take    (take)
  );

`ifdef SEQ_SINGLE_STEP_EN
  logic step_q;
  logic step_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
  end

  assign step_rise = step && !step_q;

  // Every entry into FETCH from IDLE or EXEC parks here first.
  localparam state_t ST_RESUME = ST_STEP_WAIT;
`else
  localparam state_t ST_RESUME = ST_FETCH;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_RESUME;
      ST_FETCH: if (imem_ack) state_next = ST_EXEC;
      ST_EXEC:  state_next = (opcode_o == OP_HALT) ? ST_HALT : ST_RESUME;
      ST_HALT:  state_next = ST_HALT;
`ifdef SEQ_SINGLE_STEP_EN
      ST_STEP_WAIT: if (step_rise) state_next = ST_FETCH;
`endif
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs decode straight from the state register, so an async reset drops imem_req immediately.
  always_comb begin
    imem_req = 1'b0;
    issue    = 1'b0;
    busy     = 1'b0;
    halted   = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        busy     = 1'b1;
      end
      ST_EXEC: begin
        busy  = 1'b1;
        issue = is_alu_op(opcode_o);
      end
      ST_HALT:  halted = 1'b1;
      default:  ;
    endcase
  end

  // PC and instruction registers; a not-taken jump leaves the already-incremented PC alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      opcode_o <= '0;
      lit_o    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) pc <= RESET_PC;
        ST_FETCH: begin
          if (imem_ack) begin
            opcode_o <= word.opcode;
            lit_o    <= word.k8;
            pc       <= pc + 1'b1;
          end
        end
        ST_EXEC: if (is_jump && take) pc <= lit_o[PC_W-1:0];
        default: ;
      endcase
    end
  end

  assign imem_addr = pc;
  assign pc_o      = pc;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a ROM responder serves fetches, issued words are checked
// against an expected queue. Exercises SEQ_SINGLE_STEP_EN when that macro is defined.
`timescale 1ns/1ps
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [14:0] imem_data = '0;
  logic [3:0]  flags_status = '0;
  logic [6:0]  opcode_o;
  logic [7:0]  lit_o;
  logic        issue;
  logic [7:0]  pc_o;
  logic        busy;
  logic        halted;

  logic        start4 = 1'b0;
  logic        imem_req4;
  logic [3:0]  imem_addr4;
  logic        imem_ack4 = 1'b0;
  logic [14:0] imem_data4 = '0;
  logic [6:0]  opcode4;
  logic [7:0]  lit4;
  logic        issue4;
  logic [3:0]  pc4;
  logic        busy4;
  logic        halted4;

`ifdef SEQ_SINGLE_STEP_EN
  logic step = 1'b0;
  logic auto_step = 1'b1;
`endif

  logic [14:0] rom [256];
  int          ack_wait = 0;
  logic        force_ack = 1'b0;
  int          req_cnt = 0;
  logic [14:0] expq[$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  instr_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
`ifdef SEQ_SINGLE_STEP_EN
    .step         (step),
`endif
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data),
    .flags_status (flags_status),
    .opcode_o     (opcode_o),
    .lit_o        (lit_o),
    .issue        (issue),
    .pc_o         (pc_o),
    .busy         (busy),
    .halted       (halted)
  );

  instr_sequencer #(.PC_W(4), .RESET_PC(4'hF)) dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start4),
`ifdef SEQ_SINGLE_STEP_EN
    .step         (step),
`endif
    .imem_req     (imem_req4),
    .imem_addr    (imem_addr4),
    .imem_ack     (imem_ack4),
    .imem_data    (imem_data4),
    .flags_status (4'h0),
    .opcode_o     (opcode4),
    .lit_o        (lit4),
    .issue        (issue4),
    .pc_o         (pc4),
    .busy         (busy4),
    .halted       (halted4)
  );

  // ROM responder: acks after ack_wait idle request cycles.
  initial forever begin
    @(negedge clk);
    if (force_ack) begin
      imem_ack  = 1'b1;
      imem_data = rom[imem_addr];
    end else if (imem_req) begin
      if (req_cnt >= ack_wait) begin
        imem_ack  = 1'b1;
        imem_data = rom[imem_addr];
        req_cnt   = 0;
      end else begin
        imem_ack = 1'b0;
        req_cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      req_cnt  = 0;
    end
  end

`ifdef SEQ_SINGLE_STEP_EN
  initial forever begin
    @(negedge clk);
    if (auto_step) step = ~step;
  end
`endif

  // Scoreboard: every issue strobe must match the oldest expected word.
  initial forever begin
    logic [14:0] exp_word;
    @(negedge clk);
    if (issue === 1'b1) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL issue_unexpected: got opcode=%h lit=%h, required no issue", opcode_o, lit_o);
      end else begin
        exp_word = expq.pop_front();
        if ({opcode_o, lit_o} !== exp_word) begin
          bad++;
          $display("FAIL issue_word: got %h_%h, required %h_%h", opcode_o, lit_o,
                   exp_word[14:8], exp_word[7:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = {7'h30, 8'h00};
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    start        = 1'b0;
    start4       = 1'b0;
    imem_ack4    = 1'b0;
    force_ack    = 1'b0;
    ack_wait     = 0;
    flags_status = '0;
    expq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_halted(input string name, input int budget);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (halted !== 1'b1) begin
      bad++;
      $display("FAIL %s: halted=%b after %0d cycles, required 1", name, halted, n);
    end
  endtask

  task automatic check_queue_empty(input string name);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d expected issues outstanding, required 0", name, expq.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({imem_req, issue, busy, halted} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_strobes: got req/issue/busy/halted=%b, required 0000",
               {imem_req, issue, busy, halted});
    end
    total++;
    if (pc_o !== 8'h00 || opcode_o !== 7'h00 || lit_o !== 8'h00) begin
      bad++;
      $display("FAIL reset_regs: got pc=%h op=%h lit=%h, required 00/00/00", pc_o, opcode_o, lit_o);
    end
    total++;
    if (pc4 !== 4'hF || {imem_req4, issue4, busy4, halted4} !== 4'b0000 ||
        opcode4 !== 7'h00 || lit4 !== 8'h00) begin
      bad++;
      $display("FAIL reset_dut4: got pc=%h strobes=%b op=%h lit=%h, required f/0000/00/00",
               pc4, {imem_req4, issue4, busy4, halted4}, opcode4, lit4);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (imem_req !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_without_start: got req=%b busy=%b, required 0 0", imem_req, busy);
    end
  endtask

  task automatic test_fetch();
    int n = 0;
    int hold = 0;
    do_reset();
    fill_rom();
    rom[0]   = {7'h02, 8'h05};
    rom[1]   = {OP_HALT, 8'h00};
    ack_wait = 2;
    expq.push_back({7'h02, 8'h05});
    start = 1'b1;
    while (imem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    while (imem_req === 1'b1 && imem_addr === 8'h00 && hold < 20) begin
      hold++;
      @(negedge clk);
    end
    total++;
    if (hold !== 3) begin
      bad++;
      $display("FAIL fetch_hold: addr 0 requested %0d cycles, required 3", hold);
    end
    total++;
    if (issue !== 1'b1 || opcode_o !== 7'h02 || lit_o !== 8'h05) begin
      bad++;
      $display("FAIL fetch_exec: got issue=%b op=%h lit=%h, required 1/02/05", issue, opcode_o, lit_o);
    end
    total++;
    if (pc_o !== 8'h01) begin
      bad++;
      $display("FAIL fetch_pc: got %h, required 01", pc_o);
    end
    wait_halted("fetch_halt", 100);
    check_queue_empty("fetch_queue");
  endtask

  task automatic test_jumps();
    logic [6:0] jop [10];
    logic [3:0] jfl [10];
    bit         jtk [10];
    logic [7:0] exp_pc;
    jop = '{OP_JEQ, OP_JEQ, OP_JNE, OP_JNE, OP_JGT, OP_JGT, OP_JGT, OP_JLT, OP_JLT, OP_JMP};
    jfl = '{4'h8,   4'h0,   4'h0,   4'h8,   4'h0,   4'h4,   4'h8,   4'h4,   4'h3,   4'h0};
    jtk = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b0,   1'b1,   1'b0,   1'b1};
    for (int i = 0; i < 10; i++) begin
      int n = 0;
      do_reset();
      fill_rom();
      rom[0]  = {7'h0A, 8'h05};
      rom[1]  = {jop[i], 8'h10};
      rom[2]  = {OP_HALT, 8'h00};
      rom[16] = {OP_HALT, 8'h00};
      flags_status = jfl[i];
      expq.push_back({7'h0A, 8'h05});
      start = 1'b1;
      while (!(busy === 1'b1 && imem_req === 1'b0 && opcode_o === jop[i]) && n < 100) begin
        @(negedge clk);
        n++;
      end
      start = 1'b0;
      total++;
      if (issue !== 1'b0 || n >= 100) begin
        bad++;
        $display("FAIL jump%0d_issue: got issue=%b after %0d cycles, required 0 in jump EXEC", i, issue, n);
      end
      @(negedge clk);
      exp_pc = jtk[i] ? 8'h10 : 8'h02;
      total++;
      if (pc_o !== exp_pc) begin
        bad++;
        $display("FAIL jump%0d_pc: op=%h flags=%h got pc=%h, required %h", i, jop[i], jfl[i], pc_o, exp_pc);
      end
      wait_halted("jump_halt", 100);
      check_queue_empty("jump_queue");
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    do_reset();
    fill_rom();
    rom[0] = {7'h01, 8'hAA};
    rom[1] = {7'h30, 8'h11};
    rom[2] = {7'h24, 8'hBB};
    rom[3] = {7'h25, 8'h22};
    rom[4] = {OP_HALT, 8'h00};
    expq.push_back({7'h01, 8'hAA});
    expq.push_back({7'h24, 8'hBB});
    start = 1'b1;
    while (halted !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    total++;
    if (halted !== 1'b1) begin
      bad++;
      $display("FAIL b2b_halt: halted=%b after %0d cycles, required 1", halted, n);
    end
`ifndef SEQ_SINGLE_STEP_EN
    total++;
    if (n !== 11) begin
      bad++;
      $display("FAIL b2b_latency: halted after %0d cycles, required 11", n);
    end
`endif
    total++;
    if (pc_o !== 8'h05 || opcode_o !== OP_HALT) begin
      bad++;
      $display("FAIL b2b_final: got pc=%h op=%h, required 05/7f", pc_o, opcode_o);
    end
    check_queue_empty("b2b_queue");
  endtask

  task automatic test_wrap();
    int n = 0;
    do_reset();
    start4 = 1'b1;
    while (imem_req4 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    start4 = 1'b0;
    total++;
    if (imem_req4 !== 1'b1 || imem_addr4 !== 4'hF) begin
      bad++;
      $display("FAIL wrap_first: got req=%b addr=%h, required 1/f", imem_req4, imem_addr4);
    end
    imem_ack4  = 1'b1;
    imem_data4 = {7'h30, 8'h00};
    @(negedge clk);
    imem_ack4 = 1'b0;
    total++;
    if (pc4 !== 4'h0) begin
      bad++;
      $display("FAIL wrap_pc: got %h, required 0", pc4);
    end
    n = 0;
    while (imem_req4 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (imem_req4 !== 1'b1 || imem_addr4 !== 4'h0) begin
      bad++;
      $display("FAIL wrap_next: got req=%b addr=%h, required 1/0", imem_req4, imem_addr4);
    end
    imem_ack4  = 1'b1;
    imem_data4 = {OP_JMP, 8'h1A};
    @(negedge clk);
    imem_ack4 = 1'b0;
    n = 0;
    while (imem_req4 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (imem_addr4 !== 4'hA) begin
      bad++;
      $display("FAIL wrap_jump_trunc: got addr=%h, required a", imem_addr4);
    end
  endtask

  task automatic test_halt();
    int reqs = 0;
    do_reset();
    fill_rom();
    rom[0] = {OP_HALT, 8'h00};
    start = 1'b1;
    wait_halted("halt_reach", 100);
    total++;
    if (busy !== 1'b0 || issue !== 1'b0) begin
      bad++;
      $display("FAIL halt_outputs: got busy=%b issue=%b, required 0 0", busy, issue);
    end
    force_ack = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (imem_req !== 1'b0) reqs++;
    end
    total++;
    if (reqs !== 0 || halted !== 1'b1) begin
      bad++;
      $display("FAIL halt_sticky: got %0d req cycles halted=%b, required 0 and 1", reqs, halted);
    end
    force_ack = 1'b0;
    start     = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    int n = 0;
    int reqs = 0;
    do_reset();
    fill_rom();
    rom[0]   = {7'h02, 8'h05};
    ack_wait = 1000;
    start    = 1'b1;
    while (imem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b0 || issue !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_strobes: got req=%b issue=%b busy=%b, required 0 0 0", imem_req, issue, busy);
    end
    total++;
    if (pc_o !== 8'h00) begin
      bad++;
      $display("FAIL midreset_pc: got %h, required 00", pc_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (imem_req !== 1'b0) reqs++;
    end
    total++;
    if (reqs !== 0) begin
      bad++;
      $display("FAIL midreset_idle: got %0d req cycles, required 0", reqs);
    end
    ack_wait = 0;
  endtask

`ifdef SEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    int execs = 0;
    do_reset();
    fill_rom();
    rom[3]    = {OP_HALT, 8'h00};
    auto_step = 1'b0;
    step      = 1'b0;
    start     = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (busy === 1'b1 && imem_req === 1'b0) execs++;
      if (cyc == 2) start = 1'b0;
      step = (cyc == 10 || cyc == 30 || cyc == 50);
      if (cyc == 9 || cyc == 29 || cyc == 49 || cyc == 60) begin
        total++;
        if (execs !== (cyc == 9 ? 0 : cyc == 29 ? 1 : cyc == 49 ? 2 : 3)) begin
          bad++;
          $display("FAIL step_count_c%0d: got %0d executed words", cyc, execs);
        end
      end
      if (cyc == 20) begin
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL step_wait_busy: got %b, required 0", busy);
        end
      end
    end
    auto_step = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_jumps();
    test_back_to_back();
    test_wrap();
    test_halt();
    test_reset_mid_fetch();
`ifdef SEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
